// File: rtl/vga_rx.sv
// Sink-side VGA timing decoder: recovers pixel coordinates from an
// hsync/vsync/valid/RGB stream and checks line, frame and active geometry.
module vga_rx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        valid,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        err_clr,
    output logic        pix_we,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        locked,
    output logic        err_hline,
    output logic        err_vframe,
    output logic        err_active
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam logic [9:0] H_ACT = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] H_TOT = 10'(H_TOTAL);
    localparam logic [9:0] V_TOT = 10'(V_TOTAL);

    state_t      state, state_nx;
    logic        s1_hsync, s1_vsync, s1_valid, s1_err_clr;
    logic [23:0] s1_rgb;
    logic        hs_prev, vs_prev;
    logic        hfall, vfall, running;
    logic [9:0]  h_len, col, row, v_lines;
    logic [9:0]  row_upd, vlines_upd, col_eff, row_eff;
    logic        line_valid, h_armed, frame_bad;
    logic        in_area, wr;
    logic        ev_line, ev_frame, ev_active, any_err, frame_clean, done_d;

    // Stage 1. Sync registers idle high so reset release never looks like a falling edge.
    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            s1_hsync   <= 1'b1;
            s1_vsync   <= 1'b1;
            s1_valid   <= 1'b0;
            s1_err_clr <= 1'b0;
            s1_rgb     <= '0;
            hs_prev    <= 1'b1;
            vs_prev    <= 1'b1;
        end else begin
            s1_hsync   <= hsync;
            s1_vsync   <= vsync;
            s1_valid   <= valid;
            s1_err_clr <= err_clr;
            s1_rgb     <= {vga_r, vga_g, vga_b};
            hs_prev    <= s1_hsync;
            vs_prev    <= s1_vsync;
        end
    end

    assign hfall   = hs_prev & ~s1_hsync;
    assign vfall   = vs_prev & ~s1_vsync;
    assign running = (state != IDLE);

    // Line end is folded in before frame end, then the pixel of this cycle
    // lands on the freshly updated coordinates.
    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        row_upd    = row;
        vlines_upd = v_lines + {9'd0, hfall};
        if (hfall && line_valid) row_upd = row + 10'd1;
        col_eff    = hfall ? 10'd0 : col;
        row_eff    = vfall ? 10'd0 : row_upd;
        in_area    = (col_eff < H_ACT) && (row_eff < V_ACT);
        wr         = running && s1_valid && in_area;
        ev_line    = running && hfall && h_armed && (h_len != H_TOT);
        ev_frame   = running && vfall && (vlines_upd != V_TOT);
        ev_active  = running && ((s1_valid && !in_area) ||
                                 (hfall && line_valid && (col != H_ACT)) ||
                                 (vfall && (row_upd != V_ACT)));
        any_err    = ev_line || ev_frame || ev_active;
        frame_clean = !frame_bad && !any_err;
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            h_len      <= '0;
            col        <= '0;
            row        <= '0;
            v_lines    <= '0;
            line_valid <= 1'b0;
            h_armed    <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            if (hfall)                h_len <= 10'd1;
            else if (h_len != 10'h3FF) h_len <= h_len + 10'd1;

            if (wr)         col <= col_eff + 10'd1;
            else if (hfall) col <= '0;

            row     <= vfall ? 10'd0 : row_upd;
            v_lines <= vfall ? 10'd0 : vlines_upd;

            if (hfall)         line_valid <= s1_valid;
            else if (s1_valid) line_valid <= 1'b1;

            // The first hfall after leaving IDLE only arms the line-length check.
            if (!running)   h_armed <= 1'b0;
            else if (hfall) h_armed <= 1'b1;

            if (vfall)        frame_bad <= 1'b0;
            else if (any_err) frame_bad <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (vfall)                state_nx = MEASURE;
            MEASURE: if (vfall && frame_clean) state_nx = LOCKED;
            LOCKED:  if (any_err)              state_nx = MEASURE;
            default:                           state_nx = IDLE;
        endcase
    end

    always_comb begin
        locked = 1'b0;
        done_d = 1'b0;
        if (state == LOCKED) begin
            locked = 1'b1;
            done_d = vfall && frame_clean;
        end
    end

    // Stage 2 outputs; an error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            pix_we     <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_data   <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            err_hline  <= 1'b0;
            err_vframe <= 1'b0;
            err_active <= 1'b0;
        end else begin
            pix_we <= wr;
            if (wr) begin
                pix_x    <= col_eff;
                pix_y    <= row_eff;
                pix_data <= s1_rgb;
            end
            frame_done <= done_d;
            if (done_d) frame_cnt <= frame_cnt + 16'd1;

            if (ev_line)         err_hline <= 1'b1;
            else if (s1_err_clr) err_hline <= 1'b0;
            if (ev_frame)        err_vframe <= 1'b1;
            else if (s1_err_clr) err_vframe <= 1'b0;
            if (ev_active)       err_active <= 1'b1;
            else if (s1_err_clr) err_active <= 1'b0;
        end
    end

endmodule

// File: doc/vga_rx.md
Name: vga_rx

Overview:
- Sink-side VGA timing decoder: samples an incoming hsync/vsync/valid/RGB stream, one pixel per pclk, and recovers pixel coordinates.
- Emits a pixel write strobe for a frame-capture buffer or a scoreboard.
- Checks line, frame and active-area geometry against 640x480@800x525 timing.
- Sits downstream of the VGA timing generator in loopback and self-check builds.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
H_TOTAL, 800, pclk cycles per line (hsync-fall to hsync-fall)
V_TOTAL, 525, lines per frame (vsync-fall to vsync-fall)

Ports:
pclk  input  1  pixel clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
hsync  input  1  line sync; pulse is active-low, falling edge = line start
vsync  input  1  frame sync; pulse is active-low, falling edge = frame start
valid  input  1  active-area (not blanking) indicator
vga_r, vga_g, vga_b  input  8 each  pixel colour
err_clr  input  1  one-cycle pulse; clears the sticky error flags
pix_we  output  1  captured pixel valid
pix_x  output  10  pixel column, 0..H_ACTIVE-1
pix_y  output  10  pixel row, 0..V_ACTIVE-1
pix_data  output  24  {r,g,b}
frame_done  output  1  one-cycle pulse at each frame end while LOCKED
frame_cnt  output  16  count of frame_done pulses; wraps
locked  output  1  high in LOCKED state
err_hline  output  1  sticky: line length != H_TOTAL
err_vframe  output  1  sticky: frame length != V_TOTAL
err_active  output  1  sticky: active geometry mismatch

Behaviour:
- Reset (asynchronous assert while reset=0):
  - All outputs and counters = 0; state = IDLE.
  - Previous-sync registers = 1, so no false edge fires at release.
- Stage 1 registers all inputs. Edge detect compares stage-1 sync with its previous value: hfall = prev 1 and now 0; same rule for vfall.
- Stage 2 drives the pix_* outputs. Latency is 2 pclk from the input pixel to pix_we/pix_x/pix_y/pix_data.
- h_len:
  - Set to 1 on an hfall cycle; otherwise increments, saturating at 1023.
  - On each hfall after the first since leaving IDLE: h_len != H_TOTAL -> line error.
- Column counter: cleared on hfall. Each stage-1 valid cycle with column < H_ACTIVE and row < V_ACTIVE, and state != IDLE:
  - issue pix_we with pix_x = column, pix_y = row;
  - column then increments.
- Overflow: a valid cycle with column >= H_ACTIVE or row >= V_ACTIVE does not write and raises an active error.
- Line end (hfall):
  - If the line just ended had >= 1 valid cycle: column != H_ACTIVE -> active error; row increments.
  - v_lines increments.
- Frame end (vfall):
  - Coincident hfall line-end processing is applied first; the checks below use the updated row and v_lines values.
  - v_lines != V_TOTAL -> frame error; row != V_ACTIVE -> active error.
  - Then row = 0 and v_lines = 0.
  - The first vfall after IDLE performs no checks.
- Errors:
  - Each error sets its sticky flag only in MEASURE or LOCKED.
  - err_clr clears the flags; an error event in the same cycle wins (flag stays 1).
- FSM:
  - IDLE -> MEASURE on the first vfall.
  - MEASURE -> LOCKED on a vfall that ends a frame with no line, frame or active error in that frame.
  - MEASURE otherwise stays MEASURE (the per-frame error record is cleared each vfall).
  - LOCKED -> MEASURE on any error event, in the cycle it is detected.
- frame_done: high for one cycle on a vfall taken while LOCKED with no error in that frame; frame_cnt increments in the same cycle, 0xFFFF -> 0.
- pix_we is never asserted in IDLE; pix_x/pix_y/pix_data hold their last values when pix_we = 0.

Test Plan:
- Reset asserted mid-line during LOCKED: all outputs go to 0 asynchronously. After release plus a clean 800x525 stream: IDLE, then MEASURE at first vfall, locked = 1 at second vfall.
- Two clean frames from the timing generator: exactly 307200 pix_we per frame; first write at (0,0), last at (639,479); pix_data equals the input RGB delayed 2 cycles; frame_done pulses; frame_cnt = 1 then 2.
- One line of 799 cycles while LOCKED: err_hline = 1 and locked = 0 at that hfall. err_clr clears the flag; locked returns after the next clean frame.
- Frame of 524 lines: err_vframe = 1 at vfall, no frame_done that frame.
- Line with 641 valid cycles: the 641st pixel is not written; err_active = 1.
- hsync and vsync falling in the same cycle (generator wrap): counted correctly, no error raised. err_clr coincident with a new error: flag stays 1.
